// File: rtl/flag_ctrl4_pkg.sv
// Shared flag layout, condition-code encoding and condition evaluator
// for the flag controller and its save stack.
package flag_ctrl4_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
        logic res;
        res = 1'b0;
        case (cond)
            COND_EQ: res = f.z;
            COND_NE: res = ~f.z;
            COND_CS: res = f.c;
            COND_CC: res = ~f.c;
            COND_MI: res = f.n;
            COND_PL: res = ~f.n;
            COND_VS: res = f.v;
            COND_VC: res = ~f.v;
            COND_HI: res = f.c & ~f.z;
            COND_LS: res = ~f.c | f.z;
            COND_GE: res = (f.n == f.v);
            COND_LT: res = (f.n != f.v);
            COND_GT: res = ~f.z & (f.n == f.v);
            COND_LE: res = f.z | (f.n != f.v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack4.sv
// LIFO save stack for flag values. The caller supplies already-qualified
// push/pop strobes; storage is not reset and is only read after a push.
module flag_stack4
    import flag_ctrl4_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  logic   pop_i,
    input  flags_t wdata_i,
    output flags_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SpW = AW + 1;
    localparam logic [SpW-1:0] SpOne  = 1;
    localparam logic [AW-1:0]  IdxOne = 1;

    logic [SpW-1:0] sp_q, sp_d;
    logic [AW-1:0]  rd_idx;
    flags_t         mem_q [DEPTH];

    always_comb begin
        sp_d = sp_q;
        if (push_i) begin
            sp_d = sp_q + SpOne;
        end else if (pop_i) begin
            sp_d = sp_q - SpOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q[AW-1:0]] <= wdata_i;
        end
    end

    // Low bits wrap correctly at sp==DEPTH, giving entry DEPTH-1.
    assign rd_idx  = sp_q[AW-1:0] - IdxOne;
    assign rdata_o = mem_q[rd_idx];
    assign full_o  = (sp_q == SpW'(DEPTH));
    assign empty_o = (sp_q == '0);

endmodule

// File: rtl/flag_ctrl4.sv
// Flag register with condition evaluator and a save/restore stack.
// Condition results are registered against the pre-edge flag value.
module flag_ctrl4
    import flag_ctrl4_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_we,
    input  logic       c_in,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       v_in,
    input  logic       push,
    input  logic       pop,
    input  logic       cond_req,
    input  logic [3:0] cond,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v,
    output logic       taken,
    output logic       taken_valid,
    output logic       full,
    output logic       empty,
    output logic       err
);

    flags_t flags_q, flags_d, flags_in, stack_top;
    logic   taken_q, taken_d;
    logic   taken_valid_q;
    logic   err_q, err_d;
    logic   push_ok, pop_ok, bad_op;

    assign flags_in = '{n: n_in, z: z_in, c: c_in, v: v_in};

    // Simultaneous push+pop cancels out and is not an error.
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign bad_op  = (push & ~pop & full) | (pop & ~push & empty);

    flag_stack4 #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .pop_i   (pop_ok),
        .wdata_i (flags_q),
        .rdata_o (stack_top),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        flags_d = flags_q;
        taken_d = taken_q;
        err_d   = err_q | bad_op;
        if (pop_ok) begin
            flags_d = stack_top;
        end else if (flag_we) begin
            flags_d = flags_in;
        end
        if (cond_req) begin
            taken_d = cond_eval(cond, flags_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q       <= '0;
            taken_q       <= 1'b0;
            taken_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            taken_q       <= taken_d;
            taken_valid_q <= cond_req;
            err_q         <= err_d;
        end
    end

    assign n           = flags_q.n;
    assign z           = flags_q.z;
    assign c           = flags_q.c;
    assign v           = flags_q.v;
    assign taken       = taken_q;
    assign taken_valid = taken_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_flag_ctrl4.sv
// Directed bench for flag_ctrl4: a vector table for the main sequence plus
// hand-written reset, push/pop-collision and stack-edge sequences.
module tb_flag_ctrl4;

    typedef struct {
        logic       we;
        logic [3:0] din;     // {n,z,c,v}
        logic       push;
        logic       pop;
        logic       creq;
        logic [3:0] cond;
        logic [8:0] exp;     // {n,z,c,v,taken,taken_valid,full,empty,err}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_we = 1'b0;
    logic [3:0] din = 4'h0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       cond_req = 1'b0;
    logic [3:0] cond = 4'h0;
    logic       c, n, z, v, taken, taken_valid, full, empty, err;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    localparam logic [8:0] RstVal = 9'b0000_0_0_0_1_0;

    flag_ctrl4 #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .flag_we     (flag_we),
        .c_in        (din[1]),
        .n_in        (din[3]),
        .z_in        (din[2]),
        .v_in        (din[0]),
        .push        (push),
        .pop         (pop),
        .cond_req    (cond_req),
        .cond        (cond),
        .c           (c),
        .n           (n),
        .z           (z),
        .v           (v),
        .taken       (taken),
        .taken_valid (taken_valid),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {n, z, c, v, taken, taken_valid, full, empty, err};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got nzcv_t_tv_f_e_err=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] d, input logic pu, input logic po,
                         input logic cr, input logic [3:0] cd);
        flag_we  = we;
        din      = d;
        push     = pu;
        pop      = po;
        cond_req = cr;
        cond     = cd;
    endtask

    task automatic step(input string name, input logic we, input logic [3:0] d,
                        input logic pu, input logic po, input logic cr, input logic [3:0] cd,
                        input logic [8:0] exp);
        @(negedge clk);
        drive(we, d, pu, po, cr, cd);
        @(posedge clk);
        #1;
        check(name, outs(), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        rst = 1'b1;
        #1;
        check("reset_async", outs(), RstVal);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] d, input logic pu,
                                input logic po, input logic cr, input logic [3:0] cd,
                                input logic [8:0] exp);
        vec_t r;
        r.we = we; r.din = d; r.push = pu; r.pop = po; r.creq = cr; r.cond = cd; r.exp = exp;
        return r;
    endfunction

    initial begin
        // Flag load and condition evaluation
        vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 4'h0, 9'b0100_0_0_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h0, 9'b0100_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h1, 9'b0100_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 9'b0100_0_0_0_1_0));
        vecs.push_back(mk(1, 4'b1000, 0, 0, 0, 4'h0, 9'b1000_0_0_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hA, 9'b1000_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hB, 9'b1000_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hC, 9'b1000_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hD, 9'b1000_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 9'b1000_1_0_0_1_0));
        // Same-edge flag_we: HI evaluated against old flags 1000
        vecs.push_back(mk(1, 4'b0010, 0, 0, 1, 4'h8, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h8, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h9, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h2, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h3, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h4, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h5, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h6, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'h7, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hE, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hF, 9'b0010_0_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4'hA, 9'b0010_1_1_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 9'b0010_1_0_0_1_0));
        // Fill the stack with four distinct values
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 4'h0, 9'b0001_1_0_0_1_0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'h0, 9'b0001_1_0_0_0_0));
        vecs.push_back(mk(1, 4'b0011, 0, 0, 0, 4'h0, 9'b0011_1_0_0_0_0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'h0, 9'b0011_1_0_0_0_0));
        vecs.push_back(mk(1, 4'b0111, 0, 0, 0, 4'h0, 9'b0111_1_0_0_0_0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'h0, 9'b0111_1_0_0_0_0));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 4'h0, 9'b1111_1_0_0_0_0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'h0, 9'b1111_1_0_1_0_0));
        // Overflowing push: flag_we still honoured, err set
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 4'h0, 9'b0000_1_0_1_0_1));
        // LIFO restore
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 9'b1111_1_0_0_0_1));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 9'b0111_1_0_0_0_1));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 9'b0011_1_0_0_0_1));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 9'b0001_1_0_0_1_1));
        vecs.push_back(mk(1, 4'b1010, 0, 1, 0, 4'h0, 9'b1010_1_0_0_1_1));

        @(posedge clk);
        #1;
        check("reset_hold", outs(), RstVal);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].we, vecs[i].din, vecs[i].push, vecs[i].pop,
                 vecs[i].creq, vecs[i].cond, vecs[i].exp);
        end

        // push+pop together: no stack change, no err, flag_we honoured
        do_reset();
        step("pushpop_we", 1, 4'b0101, 1, 1, 0, 4'h0, 9'b0101_0_0_0_1_0);
        // Pop on empty with flag_we 1111
        step("pop_empty_we", 1, 4'b1111, 0, 1, 0, 4'h0, 9'b1111_0_0_0_1_1);
        step("err_sticky", 0, 4'b0000, 0, 0, 0, 4'h0, 9'b1111_0_0_0_1_1);

        // push+flag_we saves the old value; pop beats flag_we
        do_reset();
        step("load_0010", 1, 4'b0010, 0, 0, 0, 4'h0, 9'b0010_0_0_0_1_0);
        step("push_we", 1, 4'b1000, 1, 0, 0, 4'h0, 9'b1000_0_0_0_0_0);
        step("idle", 0, 4'b0000, 0, 0, 0, 4'h0, 9'b1000_0_0_0_0_0);
        step("pop_over_we", 1, 4'b1111, 0, 1, 0, 4'h0, 9'b0010_0_0_0_1_0);

        // Reset in the cycle after cond_req kills the strobe
        do_reset();
        step("creq_al", 0, 4'b0000, 0, 0, 1, 4'hE, 9'b0000_1_1_0_1_0);
        #1;
        rst = 1'b1;
        cond_req = 1'b0;
        #1;
        check("mid_reset", outs(), RstVal);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rel%0d", k), outs(), RstVal);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
